id_ex_alu_ctrl: RTL and testbench

Decode-to-execute producer for the ALU's alu_control/input1/input2 interface. Accepts a fetched MIPS-style instruction with register-file read data and decodes opcode/funct into the 4-bit ALU operation code. It also selects operand 2 (register or extended immediate) and registers everything into a valid/ready ID/EX pipeline slot feeding the execute stage. Counts illegal instructions for debug.

---
 rtl/id_ex_alu_ctrl_pkg.sv | 36 +++
 rtl/id_ex_alu_ctrl_decoder.sv | 79 +++++++
 rtl/id_ex_alu_ctrl.sv | 114 +++++++++++
 tb/tb_id_ex_alu_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_alu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_alu_ctrl_pkg
// Description : Shared opcode, funct and ALU operation codes for the decode
//               stage and the ALU.
// Revision    : 1.0 - initial release
// ============================================================================
package id_ex_alu_ctrl_pkg;

    // Primary opcodes, instr[31:26]
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes, instr[5:0]
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    // ALU operation codes
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_NOP  = 4'b1111;

endpackage : id_ex_alu_ctrl_pkg
`default_nettype wire

// File: rtl/id_ex_alu_ctrl_decoder.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_decoder
// Description : Combinational instruction decode: ALU operation, operand-2
//               source/extension, destination register, write-back enable
//               and illegal-instruction flag.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_ctrl_decoder
    import id_ex_alu_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic [4:0] rt,
    input  logic [4:0] rdf,
    output logic [3:0] alu_control,
    output logic       use_imm,
    output logic       sign_ext,
    output logic [4:0] rd,
    output logic       reg_write,
    output logic       illegal
);

    // Opcode/funct decode; anything unrecognised falls through to illegal
    always_comb begin
        alu_control = ALU_NOP;
        use_imm     = 1'b0;
        sign_ext    = 1'b0;
        rd          = 5'd0;
        reg_write   = 1'b0;
        illegal     = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                rd        = rdf;
                reg_write = 1'b1;
                case (funct)
                    FN_ADD:  alu_control = ALU_ADD;
                    FN_SUB:  alu_control = ALU_SUB;
                    FN_AND:  alu_control = ALU_AND;
                    FN_OR:   alu_control = ALU_OR;
                    FN_SLT:  alu_control = ALU_SLT;
                    default: begin
                        rd        = 5'd0;
                        reg_write = 1'b0;
                        illegal   = 1'b1;
                    end
                endcase
            end
            OP_ADDI, OP_SLTI, OP_LW: begin
                alu_control = (opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
                use_imm     = 1'b1;
                sign_ext    = 1'b1;
                rd          = rt;
                reg_write   = 1'b1;
            end
            OP_ANDI, OP_ORI: begin
                alu_control = (opcode == OP_ORI) ? ALU_OR : ALU_AND;
                use_imm     = 1'b1;
                rd          = rt;
                reg_write   = 1'b1;
            end
            OP_SW: begin
                // Address computation only; nothing is written back
                alu_control = ALU_ADD;
                use_imm     = 1'b1;
                sign_ext    = 1'b1;
            end
            OP_BEQ: begin
                // Compare by subtraction of the two register operands
                alu_control = ALU_SUB;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule : alu_ctrl_decoder
`default_nettype wire

// File: rtl/id_ex_alu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_alu_ctrl
// Description : ID/EX pipeline slot producing alu_control/op1/op2 for the
//               execute stage, with valid/ready handshake, flush and a
//               saturating illegal-instruction counter.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_alu_ctrl
    import id_ex_alu_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,   // must be greater than 16 for immediate extension
    parameter int CNT_W  = 8
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        alu_control,
    output logic [DATA_W-1:0] alu_op1,
    output logic [DATA_W-1:0] alu_op2,
    output logic [4:0]        rd,
    output logic              reg_write,
    output logic              illegal,
    output logic [CNT_W-1:0]  illegal_cnt
);

    logic [3:0]        dec_alu_control;
    logic              dec_use_imm;
    logic              dec_sign_ext;
    logic [4:0]        dec_rd;
    logic              dec_reg_write;
    logic              dec_illegal;
    logic [15:0]       imm;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] op1_next;
    logic [DATA_W-1:0] op2_next;
    logic              accept;
    logic              cnt_sat;
    logic              unused_instr_bits;

    alu_ctrl_decoder u_decoder (
        .opcode      (instr[31:26]),
        .funct       (instr[5:0]),
        .rt          (instr[20:16]),
        .rdf         (instr[15:11]),
        .alu_control (dec_alu_control),
        .use_imm     (dec_use_imm),
        .sign_ext    (dec_sign_ext),
        .rd          (dec_rd),
        .reg_write   (dec_reg_write),
        .illegal     (dec_illegal)
    );

    // The rs/shamt fields are not needed: rs_data arrives already read
    assign unused_instr_bits = ^{instr[25:21], instr[10:6]};

    assign imm = instr[15:0];

    // Slot accepts whenever it is empty or being drained this cycle
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready && !flush;
    assign cnt_sat  = (illegal_cnt == {CNT_W{1'b1}});

    // Operand selection; illegal instructions present zero operands
    always_comb begin
        imm_ext  = dec_sign_ext ? {{(DATA_W-16){imm[15]}}, imm}
                                : {{(DATA_W-16){1'b0}}, imm};
        op1_next = dec_illegal ? '0 : rs_data;
        op2_next = dec_illegal ? '0 : (dec_use_imm ? imm_ext : rt_data);
    end

    // Pipeline slot: flush wins, then load on accept, else drain on consume
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            alu_control <= ALU_NOP;
            alu_op1     <= '0;
            alu_op2     <= '0;
            rd          <= 5'd0;
            reg_write   <= 1'b0;
            illegal     <= 1'b0;
        end else if (flush) begin
            out_valid   <= 1'b0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            alu_control <= dec_alu_control;
            alu_op1     <= op1_next;
            alu_op2     <= op2_next;
            rd          <= dec_rd;
            reg_write   <= dec_reg_write;
            illegal     <= dec_illegal;
        end else if (out_ready) begin
            out_valid   <= 1'b0;
        end
    end

    // Saturating count of illegal instructions actually taken into the slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_cnt <= '0;
        end else if (accept && dec_illegal && !cnt_sat) begin
            illegal_cnt <= illegal_cnt + CNT_W'(1);
        end
    end

endmodule : id_ex_alu_ctrl
`default_nettype wire

// File: tb/tb_id_ex_alu_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_alu_ctrl
// Description : Self-checking bench for id_ex_alu_ctrl: decode vector table,
//               hand-written handshake/flush/reset sequences and a random
//               run against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_alu_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  alu_control;
    logic [31:0] alu_op1;
    logic [31:0] alu_op2;
    logic [4:0]  rd;
    logic        reg_write;
    logic        illegal;
    logic [7:0]  illegal_cnt;

    int nvec = 0;
    int nmis = 0;
    int cnt_exp = 0;

    id_ex_alu_ctrl #(.DATA_W(32), .CNT_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instr       (instr),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alu_control (alu_control),
        .alu_op1     (alu_op1),
        .alu_op2     (alu_op2),
        .rd          (rd),
        .reg_write   (reg_write),
        .illegal     (illegal),
        .illegal_cnt (illegal_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  alu;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  rd;
        logic        rw;
        logic        ill;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rs;
        logic [31:0] rt;
        exp_t        e;
    } vec_t;

    // Reference decode written straight from the instruction-set table
    function automatic exp_t ref_dec(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
        exp_t        e;
        logic [5:0]  opc;
        logic [5:0]  fn;
        logic [15:0] imm;
        logic [31:0] sx;
        logic [31:0] zx;
        opc = ins[31:26];
        fn  = ins[5:0];
        imm = ins[15:0];
        sx  = 32'($signed(imm));
        zx  = {16'h0000, imm};
        e   = '{alu: 4'hF, op1: 32'h0, op2: 32'h0, rd: 5'd0, rw: 1'b0, ill: 1'b1};
        case (opc)
            6'h00: begin
                case (fn)
                    6'h20: e = '{4'h2, rs, rt, ins[15:11], 1'b1, 1'b0};
                    6'h22: e = '{4'h6, rs, rt, ins[15:11], 1'b1, 1'b0};
                    6'h24: e = '{4'h0, rs, rt, ins[15:11], 1'b1, 1'b0};
                    6'h25: e = '{4'h1, rs, rt, ins[15:11], 1'b1, 1'b0};
                    6'h2A: e = '{4'h7, rs, rt, ins[15:11], 1'b1, 1'b0};
                    default: ;
                endcase
            end
            6'h08: e = '{4'h2, rs, sx, ins[20:16], 1'b1, 1'b0};
            6'h0A: e = '{4'h7, rs, sx, ins[20:16], 1'b1, 1'b0};
            6'h0C: e = '{4'h0, rs, zx, ins[20:16], 1'b1, 1'b0};
            6'h0D: e = '{4'h1, rs, zx, ins[20:16], 1'b1, 1'b0};
            6'h23: e = '{4'h2, rs, sx, ins[20:16], 1'b1, 1'b0};
            6'h2B: e = '{4'h2, rs, sx, 5'd0, 1'b0, 1'b0};
            6'h04: e = '{4'h6, rs, rt, 5'd0, 1'b0, 1'b0};
            default: ;
        endcase
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_payload(input string tag, input exp_t e);
        chk({tag, ".alu_control"}, 32'(alu_control), 32'(e.alu));
        chk({tag, ".alu_op1"},     alu_op1,          e.op1);
        chk({tag, ".alu_op2"},     alu_op2,          e.op2);
        chk({tag, ".rd"},          32'(rd),          32'(e.rd));
        chk({tag, ".reg_write"},   32'(reg_write),   32'(e.rw));
        chk({tag, ".illegal"},     32'(illegal),     32'(e.ill));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[14];
    localparam logic [31:0] RS = 32'h1111_1111;
    localparam logic [31:0] RT = 32'h2222_2222;
    localparam exp_t RESET_E = '{4'hF, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0};

    initial begin
        bit   mv;
        exp_t mp;
        // Decode vectors with hand-computed expectations
        vecs[0]  = '{32'h0022_1820, 32'd5, 32'd7, '{4'h2, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0}};
        vecs[1]  = '{32'h2022_FFFF, RS, RT, '{4'h2, RS, 32'hFFFF_FFFF, 5'd2, 1'b1, 1'b0}};
        vecs[2]  = '{32'h3022_FFFF, RS, RT, '{4'h0, RS, 32'h0000_FFFF, 5'd2, 1'b1, 1'b0}};
        vecs[3]  = '{32'h0022_1822, RS, RT, '{4'h6, RS, RT, 5'd3, 1'b1, 1'b0}};
        vecs[4]  = '{32'h0022_1824, RS, RT, '{4'h0, RS, RT, 5'd3, 1'b1, 1'b0}};
        vecs[5]  = '{32'h0022_1825, RS, RT, '{4'h1, RS, RT, 5'd3, 1'b1, 1'b0}};
        vecs[6]  = '{32'h0022_182A, RS, RT, '{4'h7, RS, RT, 5'd3, 1'b1, 1'b0}};
        vecs[7]  = '{32'h2822_1234, RS, RT, '{4'h7, RS, 32'h0000_1234, 5'd2, 1'b1, 1'b0}};
        vecs[8]  = '{32'h3422_8000, RS, RT, '{4'h1, RS, 32'h0000_8000, 5'd2, 1'b1, 1'b0}};
        vecs[9]  = '{32'h8C22_8004, RS, RT, '{4'h2, RS, 32'hFFFF_8004, 5'd2, 1'b1, 1'b0}};
        vecs[10] = '{32'hAC22_0010, RS, RT, '{4'h2, RS, 32'h0000_0010, 5'd0, 1'b0, 1'b0}};
        vecs[11] = '{32'h1022_0003, RS, RT, '{4'h6, RS, RT, 5'd0, 1'b0, 1'b0}};
        vecs[12] = '{32'h0022_1821, RS, RT, '{4'hF, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1}};
        vecs[13] = '{32'hFC22_1820, RS, RT, '{4'hF, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1}};

        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        instr = 32'h0; rs_data = 32'h0; rt_data = 32'h0;

        // Reset and idle
        repeat (3) step();
        chk("reset.out_valid", 32'(out_valid), 32'h0);
        chk_payload("reset", RESET_E);
        chk("reset.illegal_cnt", 32'(illegal_cnt), 32'h0);
        #3 rst_n = 1'b1;
        step();
        chk("idle.out_valid", 32'(out_valid), 32'h0);
        chk("idle.alu_control", 32'(alu_control), 32'hF);
        chk("idle.in_ready", 32'(in_ready), 32'h1);
        chk("idle.illegal_cnt", 32'(illegal_cnt), 32'h0);

        // Back-to-back decode table, one payload per cycle
        out_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            in_valid = 1'b1;
            instr    = vecs[i].instr;
            rs_data  = vecs[i].rs;
            rt_data  = vecs[i].rt;
            chk($sformatf("vec%0d.in_ready", i), 32'(in_ready), 32'h1);
            step();
            if (vecs[i].e.ill) cnt_exp++;
            chk($sformatf("vec%0d.out_valid", i), 32'(out_valid), 32'h1);
            chk_payload($sformatf("vec%0d", i), vecs[i].e);
            chk($sformatf("vec%0d.illegal_cnt", i), 32'(illegal_cnt), 32'(cnt_exp));
        end
        in_valid = 1'b0;
        step();
        chk("drain.out_valid", 32'(out_valid), 32'h0);

        // Stall: sub held for 3 cycles while the next add waits
        out_ready = 1'b0; in_valid = 1'b1;
        instr = 32'h0022_1822; rs_data = 32'd3; rt_data = 32'd4;
        step();
        chk("stall.out_valid", 32'(out_valid), 32'h1);
        instr = 32'h0022_1820; rs_data = 32'd9; rt_data = 32'd10;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("stall%0d.in_ready", k), 32'(in_ready), 32'h0);
            step();
            chk($sformatf("stall%0d.out_valid", k), 32'(out_valid), 32'h1);
            chk_payload($sformatf("stall%0d", k), '{4'h6, 32'd3, 32'd4, 5'd3, 1'b1, 1'b0});
        end
        out_ready = 1'b1;
        #1 chk("release.in_ready", 32'(in_ready), 32'h1);
        step();
        chk("release.out_valid", 32'(out_valid), 32'h1);
        chk_payload("release", '{4'h2, 32'd9, 32'd10, 5'd3, 1'b1, 1'b0});
        in_valid = 1'b0;
        step();
        chk("release_drain.out_valid", 32'(out_valid), 32'h0);

        // Flush alongside an illegal instruction
        in_valid = 1'b1; flush = 1'b1; instr = 32'hFC00_0000;
        step();
        chk("flush.out_valid", 32'(out_valid), 32'h0);
        chk("flush.illegal_cnt", 32'(illegal_cnt), 32'(cnt_exp));
        flush = 1'b0;

        // 300 illegal instructions: counter saturates at 255
        for (int n = 0; n < 300; n++) begin
            step();
            if (cnt_exp < 255) cnt_exp++;
            chk("illseq.out_valid", 32'(out_valid), 32'h1);
            chk("illseq.alu_control", 32'(alu_control), 32'hF);
            chk("illseq.reg_write", 32'(reg_write), 32'h0);
            chk("illseq.illegal", 32'(illegal), 32'h1);
            chk("illseq.illegal_cnt", 32'(illegal_cnt), 32'(cnt_exp));
        end
        chk("illseq.saturated", 32'(illegal_cnt), 32'd255);
        // Flush once saturated leaves the counter alone
        flush = 1'b1;
        step();
        chk("flush_sat.out_valid", 32'(out_valid), 32'h0);
        chk("flush_sat.illegal_cnt", 32'(illegal_cnt), 32'd255);
        flush = 1'b0; in_valid = 1'b0;

        // Asynchronous reset in the middle of a stall
        out_ready = 1'b0; in_valid = 1'b1;
        instr = 32'h0022_1820; rs_data = 32'd1; rt_data = 32'd2;
        step();
        chk("areset_pre.out_valid", 32'(out_valid), 32'h1);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("areset.out_valid", 32'(out_valid), 32'h0);
        chk_payload("areset", RESET_E);
        chk("areset.illegal_cnt", 32'(illegal_cnt), 32'h0);
        cnt_exp = 0;
        #2 rst_n = 1'b1;
        in_valid = 1'b1; out_ready = 1'b1;
        instr = 32'h2022_FFFF; rs_data = 32'd6; rt_data = 32'd0;
        step();
        chk("after_reset.out_valid", 32'(out_valid), 32'h1);
        chk_payload("after_reset", '{4'h2, 32'd6, 32'hFFFF_FFFF, 5'd2, 1'b1, 1'b0});
        in_valid = 1'b0;
        step();
        chk("after_reset_drain.out_valid", 32'(out_valid), 32'h0);

        // Random traffic against the behavioural model
        mv = 1'b0;
        mp = RESET_E;
        for (int c = 0; c < 600; c++) begin
            logic [5:0] opcs [9];
            logic [5:0] fns  [6];
            logic [31:0] w;
            bit exp_rdy;
            bit acc;
            opcs = '{6'h00, 6'h00, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h04};
            fns  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00};
            w = $urandom;
            if ($urandom_range(0, 9) != 0) begin
                w[31:26] = opcs[$urandom_range(0, 8)];
                if (w[31:26] == 6'h00 && $urandom_range(0, 5) != 0)
                    w[5:0] = fns[$urandom_range(0, 4)];
            end
            instr     = w;
            rs_data   = $urandom;
            rt_data   = $urandom;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 11) == 0);
            #1;
            exp_rdy = !mv || out_ready;
            chk("rnd.in_ready", 32'(in_ready), 32'(exp_rdy));
            acc = in_valid && exp_rdy && !flush;
            if (flush) begin
                mv = 1'b0;
            end else if (acc) begin
                mv = 1'b1;
                mp = ref_dec(instr, rs_data, rt_data);
                if (mp.ill && cnt_exp < 255) cnt_exp++;
            end else if (out_ready) begin
                mv = 1'b0;
            end
            step();
            chk("rnd.out_valid", 32'(out_valid), 32'(mv));
            chk("rnd.illegal_cnt", 32'(illegal_cnt), 32'(cnt_exp));
            if (mv) chk_payload("rnd", mp);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule : tb_id_ex_alu_ctrl
`default_nettype wire
